// File: rtl/rom_load_pkg.sv
// Shared constants and types for the ROM download controller.
// Holds the ROM region map, the controller state encoding and the byte
// counter helper used by rom_load_ctrl and rom_region_decode.
package rom_load_pkg;

  localparam int unsigned IOCTL_ADDR_W = 25;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned BYTE_CNT_W   = 17;
  localparam int unsigned N_REGIONS    = 4;
  localparam int unsigned REGION_IDX_W = 2;

  // Region map: main CPU, sound CPU, tiles, sprites+PROMs (last ends at IMG_SIZE)
  localparam int unsigned REGION0_BASE = 32'h0000;
  localparam int unsigned REGION1_BASE = 32'h8000;
  localparam int unsigned REGION2_BASE = 32'hA000;
  localparam int unsigned REGION3_BASE = 32'hC000;
  localparam int unsigned REGION0_END  = REGION1_BASE;
  localparam int unsigned REGION1_END  = REGION2_BASE;
  localparam int unsigned REGION2_END  = REGION3_BASE;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_HOLD  = 3'd3,
    ST_RUN   = 3'd4,
    ST_ERR   = 3'd5
  } load_state_t;

  // Saturating increment so an oversize image never wraps back to a good count
  function automatic logic [BYTE_CNT_W-1:0] sat_inc(input logic [BYTE_CNT_W-1:0] v);
    return (&v) ? v : v + BYTE_CNT_W'(1);
  endfunction

endpackage

// File: rtl/rom_region_decode.sv
// Combinational byte-address decoder for the ROM download.
// Ports:
//   addr        in   byte address from hps_io
//   region_c    out  one-hot region select, all zero when out of range
//   offset_c    out  address minus region base, truncated to ADDR_W
//   in_range_c  out  address lies below IMG_SIZE
module rom_region_decode
  import rom_load_pkg::*;
#(
  parameter int unsigned IMG_SIZE = 32'hE000,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic [IOCTL_ADDR_W-1:0] addr,
  output logic [N_REGIONS-1:0]    region_c,
  output logic [ADDR_W-1:0]       offset_c,
  output logic                    in_range_c
);

  logic [REGION_IDX_W-1:0] idx;
  logic [IOCTL_ADDR_W-1:0] base;

  // Pick the highest region whose base the address has reached
  always_comb begin
    idx        = REGION_IDX_W'(0);
    base       = IOCTL_ADDR_W'(REGION0_BASE);
    in_range_c = (addr < IOCTL_ADDR_W'(IMG_SIZE));
    if (addr >= IOCTL_ADDR_W'(REGION3_BASE)) begin
      idx  = REGION_IDX_W'(3);
      base = IOCTL_ADDR_W'(REGION3_BASE);
    end else if (addr >= IOCTL_ADDR_W'(REGION2_BASE)) begin
      idx  = REGION_IDX_W'(2);
      base = IOCTL_ADDR_W'(REGION2_BASE);
    end else if (addr >= IOCTL_ADDR_W'(REGION1_BASE)) begin
      idx  = REGION_IDX_W'(1);
      base = IOCTL_ADDR_W'(REGION1_BASE);
    end
    region_c = in_range_c ? (N_REGIONS'(1) << idx) : '0;
    offset_c = ADDR_W'(addr - base);
  end

endmodule

// File: rtl/rom_load_ctrl.sv
// Sequences the HPS ROM download into the core's ROM write port, holds the
// game in reset during and after the load, and checks the image size.
// Ports:
//   clk_sys         in   system clock
//   reset           in   asynchronous active-high reset
//   ioctl_download  in   download window from hps_io
//   ioctl_wr        in   single-cycle byte-valid strobe
//   ioctl_addr      in   byte address
//   ioctl_dout      in   byte data
//   dn_addr         out  registered offset within the selected region
//   dn_data         out  registered byte data
//   dn_wr           out  registered one-hot region write strobe
//   game_reset      out  registered reset to the game core
//   load_err        out  sticky size/range error until the next download
//   load_done       out  good load completed, until the next download
//   byte_cnt        out  bytes accepted in the current or last download
module rom_load_ctrl
  import rom_load_pkg::*;
#(
  parameter int unsigned IMG_SIZE    = 32'hE000,
  parameter int unsigned HOLD_CYCLES = 1024,
  parameter int unsigned ADDR_W      = 16
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    ioctl_download,
  input  logic                    ioctl_wr,
  input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
  input  logic [DATA_W-1:0]       ioctl_dout,
  output logic [ADDR_W-1:0]       dn_addr,
  output logic [DATA_W-1:0]       dn_data,
  output logic [N_REGIONS-1:0]    dn_wr,
  output logic                    game_reset,
  output logic                    load_err,
  output logic                    load_done,
  output logic [BYTE_CNT_W-1:0]   byte_cnt
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  load_state_t             state;
  load_state_t             state_next;
  logic                    dl_q;
  logic [HOLD_W-1:0]       hold_cnt;

  logic [N_REGIONS-1:0]    region_c;
  logic [ADDR_W-1:0]       offset_c;
  logic                    in_range_c;

  logic [ADDR_W-1:0]       dn_addr_d;
  logic [DATA_W-1:0]       dn_data_d;
  logic [N_REGIONS-1:0]    dn_wr_d;
  logic                    game_reset_d;
  logic                    load_err_d;
  logic                    load_done_d;
  logic [BYTE_CNT_W-1:0]   byte_cnt_d;
  logic [HOLD_W-1:0]       hold_cnt_d;

  rom_region_decode #(
    .IMG_SIZE (IMG_SIZE),
    .ADDR_W   (ADDR_W)
  ) u_decode (
    .addr       (ioctl_addr),
    .region_c   (region_c),
    .offset_c   (offset_c),
    .in_range_c (in_range_c)
  );

  // State register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; RUN and ERR restart straight into LOAD on a new download
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (ioctl_download) state_next = ST_LOAD;
      ST_LOAD:  if (dl_q && !ioctl_download) state_next = ST_CHECK;
      ST_CHECK: state_next = (byte_cnt == BYTE_CNT_W'(IMG_SIZE) && !load_err) ? ST_HOLD : ST_ERR;
      ST_HOLD:  if (hold_cnt == '0) state_next = ST_RUN;
      ST_RUN:   if (ioctl_download) state_next = ST_LOAD;
      ST_ERR:   if (ioctl_download) state_next = ST_LOAD;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    dn_wr_d      = '0;
    dn_addr_d    = dn_addr;
    dn_data_d    = dn_data;
    byte_cnt_d   = byte_cnt;
    load_err_d   = load_err;
    load_done_d  = load_done;
    hold_cnt_d   = hold_cnt;
    game_reset_d = (state_next != ST_RUN);
    case (state)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (ioctl_download) begin
          byte_cnt_d  = '0;
          load_err_d  = 1'b0;
          load_done_d = 1'b0;
        end
      end
      ST_LOAD: begin
        // A byte arriving with the falling download edge is still taken here
        if (ioctl_wr) begin
          dn_wr_d    = region_c;
          dn_addr_d  = offset_c;
          dn_data_d  = ioctl_dout;
          byte_cnt_d = sat_inc(byte_cnt);
          if (!in_range_c) load_err_d = 1'b1;
        end
      end
      ST_CHECK: begin
        if (state_next == ST_HOLD) hold_cnt_d = HOLD_W'(HOLD_CYCLES - 1);
        else                       load_err_d = 1'b1;
      end
      ST_HOLD: begin
        if (hold_cnt != '0) hold_cnt_d  = hold_cnt - HOLD_W'(1);
        else                load_done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_q       <= 1'b0;
      dn_wr      <= '0;
      dn_addr    <= '0;
      dn_data    <= '0;
      game_reset <= 1'b1;
      load_err   <= 1'b0;
      load_done  <= 1'b0;
      byte_cnt   <= '0;
      hold_cnt   <= '0;
    end else begin
      dl_q       <= ioctl_download;
      dn_wr      <= dn_wr_d;
      dn_addr    <= dn_addr_d;
      dn_data    <= dn_data_d;
      game_reset <= game_reset_d;
      load_err   <= load_err_d;
      load_done  <= load_done_d;
      byte_cnt   <= byte_cnt_d;
      hold_cnt   <= hold_cnt_d;
    end
  end

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Self-checking bench for rom_load_ctrl. dut_a uses the full 0xE000 image;
// dut_b uses a 64-byte image with a short hold so the repeated good loads
// stay cheap. Both instances see the same stimulus.
module tb_rom_load_ctrl;
  import rom_load_pkg::*;

  localparam int unsigned A_IMG  = 32'hE000;
  localparam int unsigned A_HOLD = 1024;
  localparam int unsigned B_IMG  = 64;
  localparam int unsigned B_HOLD = 8;

  typedef struct packed {
    logic [3:0]  wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } strobe_t;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;

  logic [15:0] a_dn_addr, b_dn_addr;
  logic [7:0]  a_dn_data, b_dn_data;
  logic [3:0]  a_dn_wr, b_dn_wr;
  logic        a_game_reset, b_game_reset;
  logic        a_load_err, b_load_err;
  logic        a_load_done, b_load_done;
  logic [16:0] a_byte_cnt, b_byte_cnt;

  int total = 0;
  int bad = 0;
  strobe_t sb[$];

  always #5 clk_sys = ~clk_sys;

  rom_load_ctrl #(.IMG_SIZE(A_IMG), .HOLD_CYCLES(A_HOLD), .ADDR_W(16)) dut_a (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .dn_addr(a_dn_addr), .dn_data(a_dn_data), .dn_wr(a_dn_wr),
    .game_reset(a_game_reset), .load_err(a_load_err), .load_done(a_load_done),
    .byte_cnt(a_byte_cnt)
  );

  rom_load_ctrl #(.IMG_SIZE(B_IMG), .HOLD_CYCLES(B_HOLD), .ADDR_W(16)) dut_b (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .dn_addr(b_dn_addr), .dn_data(b_dn_data), .dn_wr(b_dn_wr),
    .game_reset(b_game_reset), .load_err(b_load_err), .load_done(b_load_done),
    .byte_cnt(b_byte_cnt)
  );

  // Reference region map written from the published address ranges
  function automatic strobe_t model(input logic [24:0] a, input logic [7:0] d,
                                    input int unsigned img);
    strobe_t m;
    logic [24:0] lim;
    lim    = 25'(img);
    m.data = d;
    m.wr   = 4'b0000;
    m.addr = 16'(a);
    if (a >= lim)             m.wr = 4'b0000;
    else if (a < 25'h8000) begin m.wr = 4'b0001; m.addr = 16'(a); end
    else if (a < 25'hA000) begin m.wr = 4'b0010; m.addr = 16'(a - 25'h8000); end
    else if (a < 25'hC000) begin m.wr = 4'b0100; m.addr = 16'(a - 25'hA000); end
    else                   begin m.wr = 4'b1000; m.addr = 16'(a - 25'hC000); end
    return m;
  endfunction

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic put_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    cyc();
    ioctl_wr   = 1'b0;
  endtask

  task automatic start_dl();
    ioctl_download = 1'b1;
    cyc();
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    logic [47:0] exp_v;
    exp_v = {4'b0, 16'h0, 8'h0, 1'b1, 1'b0, 1'b0, 17'h0};
    reset = 1'b1;
    repeat (3) cyc();
    total++;
    if ({a_dn_wr, a_dn_addr, a_dn_data, a_game_reset, a_load_err, a_load_done, a_byte_cnt} !== exp_v) begin
      bad++;
      $display("FAIL reset_a: got %h want %h", {a_dn_wr, a_dn_addr, a_dn_data, a_game_reset, a_load_err, a_load_done, a_byte_cnt}, exp_v);
    end
    total++;
    if ({b_dn_wr, b_dn_addr, b_dn_data, b_game_reset, b_load_err, b_load_done, b_byte_cnt} !== exp_v) begin
      bad++;
      $display("FAIL reset_b: got %h want %h", {b_dn_wr, b_dn_addr, b_dn_data, b_game_reset, b_load_err, b_load_done, b_byte_cnt}, exp_v);
    end
    reset = 1'b0;
    repeat (2) cyc();
    total++;
    if ({a_dn_wr, a_dn_addr, a_dn_data, a_game_reset, a_load_err, a_load_done, a_byte_cnt} !== exp_v) begin
      bad++;
      $display("FAIL idle_a: got %h want %h", {a_dn_wr, a_dn_addr, a_dn_data, a_game_reset, a_load_err, a_load_done, a_byte_cnt}, exp_v);
    end
  endtask

  task automatic test_region_byte();
    strobe_t e;
    start_dl();
    sb.push_back(model(25'h9003, 8'h5A, A_IMG));
    put_byte(25'h9003, 8'h5A);
    e = sb.pop_front();
    total++;
    if ({a_dn_wr, a_dn_addr, a_dn_data} !== e) begin
      bad++;
      $display("FAIL region_byte: got %h want %h", {a_dn_wr, a_dn_addr, a_dn_data}, e);
    end
    total++;
    if (a_byte_cnt !== 17'd1) begin
      bad++;
      $display("FAIL region_byte_cnt: got %0d want 1", a_byte_cnt);
    end
    total++;
    if ({b_dn_wr, b_load_err} !== {4'b0000, 1'b1}) begin
      bad++;
      $display("FAIL small_img_range: got wr=%b err=%b want wr=0000 err=1", b_dn_wr, b_load_err);
    end
    cyc();
    total++;
    if (a_dn_wr !== 4'b0000) begin
      bad++;
      $display("FAIL strobe_width: got %b want 0000", a_dn_wr);
    end
    end_dl();
    cyc();
    total++;
    if ({a_load_err, a_game_reset} !== 2'b11) begin
      bad++;
      $display("FAIL single_byte_err: got err=%b rst=%b want 1 1", a_load_err, a_game_reset);
    end
  endtask

  task automatic test_out_of_range();
    start_dl();
    total++;
    if ({a_load_err, a_byte_cnt} !== {1'b0, 17'd0}) begin
      bad++;
      $display("FAIL restart_clear: got err=%b cnt=%0d want 0 0", a_load_err, a_byte_cnt);
    end
    put_byte(25'hE000, 8'h3C);
    total++;
    if ({a_dn_wr, a_byte_cnt} !== {4'b0000, 17'd1}) begin
      bad++;
      $display("FAIL oor_strobe: got wr=%b cnt=%0d want 0000 1", a_dn_wr, a_byte_cnt);
    end
    end_dl();
    total++;
    if ({dut_a.state, a_load_err} !== {ST_CHECK, 1'b1}) begin
      bad++;
      $display("FAIL oor_check: got state=%0d err=%b want %0d 1", dut_a.state, a_load_err, ST_CHECK);
    end
    cyc();
    total++;
    if (dut_a.state !== ST_ERR) begin
      bad++;
      $display("FAIL oor_err_state: got %0d want %0d", dut_a.state, ST_ERR);
    end
  endtask

  task automatic test_full_download();
    strobe_t e;
    int cnt[4];
    int exp_cnt[4];
    int n;
    exp_cnt = '{32768, 8192, 8192, 8192};
    cnt = '{0, 0, 0, 0};
    start_dl();
    for (int i = 0; i < int'(A_IMG); i++) begin
      sb.push_back(model(25'(i), 8'(i ^ (i >> 8)), A_IMG));
      put_byte(25'(i), 8'(i ^ (i >> 8)));
      e = sb.pop_front();
      total++;
      if ({a_dn_wr, a_dn_addr, a_dn_data} !== e) begin
        bad++;
        $display("FAIL full_strobe @%h: got %h want %h", i, {a_dn_wr, a_dn_addr, a_dn_data}, e);
      end
      for (int r = 0; r < 4; r++) if (a_dn_wr[r]) cnt[r]++;
    end
    for (int r = 0; r < 4; r++) begin
      total++;
      if (cnt[r] != exp_cnt[r]) begin
        bad++;
        $display("FAIL region_count[%0d]: got %0d want %0d", r, cnt[r], exp_cnt[r]);
      end
    end
    end_dl();
    n = 0;
    while (a_game_reset === 1'b1 && n < int'(A_HOLD) + 50) begin
      cyc();
      n++;
    end
    total++;
    if (n != int'(A_HOLD) + 1) begin
      bad++;
      $display("FAIL full_hold_len: got %0d want %0d", n, A_HOLD + 1);
    end
    total++;
    if ({a_load_done, a_load_err, a_byte_cnt} !== {1'b1, 1'b0, 17'(A_IMG)}) begin
      bad++;
      $display("FAIL full_status: got done=%b err=%b cnt=%h want 1 0 %h", a_load_done, a_load_err, a_byte_cnt, A_IMG);
    end
  endtask

  task automatic test_short_image();
    int drops;
    start_dl();
    for (int i = 0; i < int'(B_IMG) - 1; i++) put_byte(25'(i), 8'(i));
    end_dl();
    cyc();
    total++;
    if ({dut_b.state, b_load_err, b_byte_cnt} !== {ST_ERR, 1'b1, 17'(B_IMG - 1)}) begin
      bad++;
      $display("FAIL short_err: got state=%0d err=%b cnt=%0d want %0d 1 %0d", dut_b.state, b_load_err, b_byte_cnt, ST_ERR, B_IMG - 1);
    end
    drops = 0;
    repeat (10000) begin
      cyc();
      if (b_game_reset !== 1'b1) drops++;
    end
    total++;
    if (drops != 0 || b_load_err !== 1'b1) begin
      bad++;
      $display("FAIL short_hold: got %0d released cycles err=%b want 0 1", drops, b_load_err);
    end
  endtask

  task automatic good_small_load(input string tag);
    strobe_t e;
    int n;
    for (int i = 0; i < int'(B_IMG) - 1; i++) begin
      sb.push_back(model(25'(i), 8'(8'hA0 + i), B_IMG));
      put_byte(25'(i), 8'(8'hA0 + i));
      e = sb.pop_front();
      total++;
      if ({b_dn_wr, b_dn_addr, b_dn_data} !== e) begin
        bad++;
        $display("FAIL %s_strobe @%0d: got %h want %h", tag, i, {b_dn_wr, b_dn_addr, b_dn_data}, e);
      end
    end
    // Last byte arrives together with the falling download edge
    sb.push_back(model(25'(B_IMG - 1), 8'hEE, B_IMG));
    ioctl_wr = 1'b1;
    ioctl_addr = 25'(B_IMG - 1);
    ioctl_dout = 8'hEE;
    ioctl_download = 1'b0;
    cyc();
    ioctl_wr = 1'b0;
    e = sb.pop_front();
    total++;
    if ({b_dn_wr, b_dn_addr, b_dn_data, b_byte_cnt} !== {e, 17'(B_IMG)}) begin
      bad++;
      $display("FAIL %s_last: got %h want %h", tag, {b_dn_wr, b_dn_addr, b_dn_data, b_byte_cnt}, {e, 17'(B_IMG)});
    end
    n = 0;
    while (b_game_reset === 1'b1 && n < int'(B_HOLD) + 50) begin
      cyc();
      n++;
    end
    total++;
    if (n != int'(B_HOLD) + 1) begin
      bad++;
      $display("FAIL %s_hold_len: got %0d want %0d", tag, n, B_HOLD + 1);
    end
    total++;
    if ({b_load_done, b_load_err} !== 2'b10) begin
      bad++;
      $display("FAIL %s_status: got done=%b err=%b want 1 0", tag, b_load_done, b_load_err);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [47:0] exp_v;
    exp_v = {4'b0, 16'h0, 8'h0, 1'b1, 1'b0, 1'b0, 17'h0};
    start_dl();
    for (int i = 0; i < 100; i++) put_byte(25'(i), 8'(i));
    total++;
    if (b_byte_cnt !== 17'd100) begin
      bad++;
      $display("FAIL mid_count: got %0d want 100", b_byte_cnt);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({a_dn_wr, a_dn_addr, a_dn_data, a_game_reset, a_load_err, a_load_done, a_byte_cnt} !== exp_v) begin
      bad++;
      $display("FAIL mid_reset_a: got %h want %h", {a_dn_wr, a_dn_addr, a_dn_data, a_game_reset, a_load_err, a_load_done, a_byte_cnt}, exp_v);
    end
    total++;
    if ({b_dn_wr, b_dn_addr, b_dn_data, b_game_reset, b_load_err, b_load_done, b_byte_cnt} !== exp_v) begin
      bad++;
      $display("FAIL mid_reset_b: got %h want %h", {b_dn_wr, b_dn_addr, b_dn_data, b_game_reset, b_load_err, b_load_done, b_byte_cnt}, exp_v);
    end
    ioctl_download = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();
    start_dl();
    good_small_load("after_reset");
  endtask

  task automatic test_redownload();
    total++;
    if (b_game_reset !== 1'b0) begin
      bad++;
      $display("FAIL run_released: got %b want 0", b_game_reset);
    end
    put_byte(25'd5, 8'h77);
    total++;
    if ({b_dn_wr, b_byte_cnt} !== {4'b0000, 17'(B_IMG)}) begin
      bad++;
      $display("FAIL wr_in_run: got wr=%b cnt=%0d want 0000 %0d", b_dn_wr, b_byte_cnt, B_IMG);
    end
    start_dl();
    total++;
    if ({b_game_reset, b_load_done, b_byte_cnt} !== {1'b1, 1'b0, 17'd0}) begin
      bad++;
      $display("FAIL redl_start: got rst=%b done=%b cnt=%0d want 1 0 0", b_game_reset, b_load_done, b_byte_cnt);
    end
    good_small_load("redl");
  endtask

  initial begin
    test_reset();
    test_region_byte();
    test_out_of_range();
    test_full_download();
    test_short_image();
    test_reset_mid_load();
    test_redownload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_load_ctrl.md
Name: rom_load_ctrl

Overview:
Sequences the HPS ROM download into the arcade core's ROM write port. Decodes the byte address into one of four ROM regions and drives the registered per-region write strobes. Holds the game in reset during the download and for a stretch after it. Counts the bytes written and checks the total against the expected image size, so a short or long image leaves the core held in reset with an error flag set.

Parameters:
IMG_SIZE, 16'hE000, expected total byte count of the ROM image.
HOLD_CYCLES, 1024, clk_sys cycles the game reset stays asserted after a good download ends.
ADDR_W, 16, width of the forwarded address.

Ports:
clk_sys  in  1  system clock (12 MHz domain)
reset  in  1  asynchronous, active-high
ioctl_download  in  1  download window from hps_io
ioctl_wr  in  1  single-cycle byte-valid strobe
ioctl_addr  in  25  byte address
ioctl_dout  in  8  byte data
dn_addr  out  ADDR_W  address offset within the selected region
dn_data  out  8  registered data
dn_wr  out  4  one-hot region write strobe: [0] main CPU, [1] sound CPU, [2] tiles, [3] sprites+PROMs
game_reset  out  1  reset to the game core
load_err  out  1  size mismatch or out-of-range byte, sticky until the next download
load_done  out  1  high after a good load, until the next download starts
byte_cnt  out  17  bytes accepted in the current or last download

Behaviour:
- Reset values: dn_wr=0, dn_addr=0, dn_data=0, game_reset=1, load_err=0, load_done=0, byte_cnt=0, state=IDLE.
- States are IDLE, LOAD, CHECK, HOLD, RUN and ERR.
- IDLE: game_reset=1. On ioctl_download=1, clear byte_cnt, load_err and load_done, then go to LOAD.
- LOAD, per ioctl_wr pulse, with one-cycle latency:
  - the next cycle drives dn_wr, dn_addr (ioctl_addr minus the region base, truncated to ADDR_W) and dn_data;
  - byte_cnt increments by 1.
- Region map, from constants in the package:
  - [0x0000,0x8000) is region 0;
  - [0x8000,0xA000) is region 1;
  - [0xA000,0xC000) is region 2;
  - [0xC000,IMG_SIZE) is region 3.
- An address >= IMG_SIZE produces no strobe and sets load_err; byte_cnt still increments.
- A falling edge of ioctl_download moves the state to CHECK. A pending registered strobe from the last byte completes normally.
- CHECK takes one cycle:
  - byte_cnt==IMG_SIZE and !load_err goes to HOLD, which loads the hold counter with HOLD_CYCLES-1;
  - otherwise set load_err and go to ERR.
- HOLD: game_reset=1 while the counter decrements. At 0, go to RUN and set load_done.
- RUN: game_reset=0. ioctl_download=1 restarts the sequence through the IDLE actions, i.e. a re-download is allowed.
- ERR: game_reset=1 indefinitely. Only a new download leaves this state.
- game_reset is a registered output, deasserted exactly HOLD_CYCLES+1 cycles after CHECK is entered.
- Simultaneous ioctl_wr and ioctl_download falling edge: the byte is accepted and counted before CHECK evaluates.
- A pulse of the reset input in any state returns to IDLE with all reset values.
- byte_cnt saturates at 17'h1FFFF; no wrap.
- ioctl_wr outside LOAD is ignored.

Decomposition:
- Package rom_load_pkg holds:
  - the region base and end localparams;
  - typedef enum logic [2:0] load_state_t;
  - the region index width.
- Optional sub-module rom_region_decode: a combinational address-to-one-hot and offset decoder. Everything else stays in rom_load_ctrl.

Test Plan:
- Full download of 0xE000 sequential bytes:
  - dn_wr[0] is asserted for 32768 strobes, dn_wr[1] and dn_wr[2] for 8192 each, dn_wr[3] for 8192;
  - game_reset falls HOLD_CYCLES+1 cycles after the download ends;
  - load_done=1 and load_err=0.
- Byte at address 0x9003 with data 8'h5A: the next cycle shows dn_wr=4'b0010, dn_addr=16'h1003, dn_data=8'h5A.
- Short image of 0xDFFF bytes: load_err=1, state ERR, game_reset stays 1 for 10000 cycles.
- Byte written at address 0xE000: no dn_wr strobe, load_err=1 at CHECK.
- Reset asserted mid-LOAD after 100 bytes: all outputs return to reset values; a following full download succeeds.
- Re-download while in RUN: game_reset rises the cycle after ioctl_download rises, load_done clears, and the sequence completes again.
